// File: rtl/uart_pkg.sv
// Shared constants, FSM encoding and byte-slot helper for the UART word receive path.
package uart_pkg;

    localparam int NB_DATA        = 32;
    localparam int NB_BYTE        = 8;
    localparam int N_BYTES        = NB_DATA / NB_BYTE;
    localparam int TIMEOUT_CYCLES = 40000;

    // IDLE means no partial word is held; COLLECT means 1..N_BYTES-1 bytes are held.
    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } rx_state_e;

    // Bit offset of byte slot 'slot' inside an nb_data-bit word.
    function automatic int slot_offset(input int slot, input bit lsb_first,
                                       input int nb_data, input int nb_byte);
        if (lsb_first) begin
            return slot * nb_byte;
        end
        return nb_data - nb_byte - slot * nb_byte;
    endfunction

endpackage

// File: rtl/uart_rx_word_assembler_if.sv
// Byte-in / word-out bundle between the UART receiver, the assembler and its consumer.
interface uart_rx_word_assembler_if #(
    parameter int NB_DATA = uart_pkg::NB_DATA,
    parameter int NB_BYTE = uart_pkg::NB_BYTE
);
    localparam int NB_COUNT = $clog2(NB_DATA / NB_BYTE) + 1;

    logic [NB_BYTE-1:0]  i_rx_byte;
    logic                i_rx_done_pulse;
    logic                i_word_read;
    logic                i_flush;
    logic [NB_DATA-1:0]  o_word;
    logic                o_word_valid;
    logic [NB_COUNT-1:0] o_byte_count;
    logic                o_timeout_pulse;
    logic                o_overrun_pulse;
    logic                o_overrun;

    // Driver side: UART receiver plus the word consumer.
    modport master (
        output i_rx_byte, i_rx_done_pulse, i_word_read, i_flush,
        input  o_word, o_word_valid, o_byte_count, o_timeout_pulse, o_overrun_pulse, o_overrun
    );

    // Assembler side.
    modport slave (
        input  i_rx_byte, i_rx_done_pulse, i_word_read, i_flush,
        output o_word, o_word_valid, o_byte_count, o_timeout_pulse, o_overrun_pulse, o_overrun
    );

endinterface

// File: rtl/uart_rx_word_assembler_timeout.sv
// Inter-byte silence counter: clear/enable counter that saturates and flags the last allowed cycle.
module rx_word_timeout #(
    parameter int NB_TIMEOUT     = 16,
    parameter int TIMEOUT_CYCLES = uart_pkg::TIMEOUT_CYCLES
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam bit                    ENABLED = (TIMEOUT_CYCLES != 0);
    localparam logic [NB_TIMEOUT-1:0] LIMIT   = NB_TIMEOUT'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    // The configured limit has to be representable by the counter.
    if (TIMEOUT_CYCLES < 0 ||
        longint'(TIMEOUT_CYCLES) > ((longint'(1) << NB_TIMEOUT) - 1)) begin : g_bad_timeout
        $error("rx_word_timeout: TIMEOUT_CYCLES does not fit in NB_TIMEOUT bits");
    end

    logic [NB_TIMEOUT-1:0] count_q, count_d;

    // Next count: clear wins, otherwise count up while enabled and hold at all-ones.
    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_enable && (count_q != '1)) begin
            count_d = count_q + NB_TIMEOUT'(1);
        end
    end

    // Counter register.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_expired = ENABLED && (count_q == LIMIT);

endmodule

// File: rtl/uart_rx_word_assembler.sv
// Assembles received UART bytes into words and holds the last word for a consumer.
module uart_rx_word_assembler #(
    parameter int NB_DATA        = uart_pkg::NB_DATA,
    parameter int NB_BYTE        = uart_pkg::NB_BYTE,
    parameter bit LSB_FIRST      = 1'b1,
    parameter int NB_TIMEOUT     = 16,
    parameter int TIMEOUT_CYCLES = uart_pkg::TIMEOUT_CYCLES
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    uart_rx_word_assembler_if.slave  bus
);

    import uart_pkg::rx_state_e;
    import uart_pkg::IDLE;
    import uart_pkg::COLLECT;
    import uart_pkg::slot_offset;

    localparam int                  N_SLOTS   = NB_DATA / NB_BYTE;
    localparam int                  NB_COUNT  = $clog2(N_SLOTS) + 1;
    localparam logic [NB_COUNT-1:0] LAST_SLOT = NB_COUNT'(N_SLOTS - 1);

    if ((NB_DATA % NB_BYTE) != 0 || N_SLOTS < 1) begin : g_bad_width
        $error("uart_rx_word_assembler: NB_DATA must be a positive multiple of NB_BYTE");
    end

    rx_state_e           state_q, state_d;
    logic [NB_COUNT-1:0] count_q, count_d;
    logic [NB_DATA-1:0]  shift_q, shift_d;
    logic [NB_DATA-1:0]  word_q, word_d;
    logic                valid_q, valid_d;
    logic                overrun_q, overrun_d;

    logic                byte_fire;
    logic                word_done;
    logic                expire;
    logic                tmr_expired;
    logic                tmr_clear;
    logic                tmr_enable;
    logic [NB_DATA-1:0]  assembled;
    int                  slot_off;

    // Qualify events: flush beats a coincident byte, and a byte beats an expiring timer.
    always_comb begin
        byte_fire = bus.i_rx_done_pulse && !bus.i_flush;
        word_done = byte_fire && (count_q == LAST_SLOT);
        expire    = (state_q == COLLECT) && !bus.i_rx_done_pulse && !bus.i_flush && tmr_expired;
    end

    // FSM state register.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        if (bus.i_flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (byte_fire && !word_done) state_d = COLLECT;
                COLLECT: if (word_done || expire)     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs: event pulses mark the cycle in which the event is decided.
    always_comb begin
        bus.o_timeout_pulse = expire;
        bus.o_overrun_pulse = word_done && valid_q && !bus.i_word_read;
    end

    // Timer runs only while a partial word is held; any byte or leaving COLLECT restarts it.
    assign tmr_clear  = bus.i_flush || bus.i_rx_done_pulse || (state_q == IDLE) || expire;
    assign tmr_enable = (state_q == COLLECT);

    rx_word_timeout #(
        .NB_TIMEOUT     (NB_TIMEOUT),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_clear   (tmr_clear),
        .i_enable  (tmr_enable),
        .o_expired (tmr_expired)
    );

    // Datapath next values: byte placement, partial-word bookkeeping and the holding register.
    always_comb begin
        slot_off  = slot_offset(int'(count_q), LSB_FIRST, NB_DATA, NB_BYTE);
        assembled = shift_q;
        assembled[slot_off +: NB_BYTE] = bus.i_rx_byte;

        count_d   = count_q;
        shift_d   = shift_q;
        word_d    = word_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        if (bus.i_flush) begin
            count_d   = '0;
            shift_d   = '0;
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end else begin
            if (expire) begin
                count_d = '0;
                shift_d = '0;
            end else if (byte_fire) begin
                if (word_done) begin
                    count_d = '0;
                    shift_d = '0;
                end else begin
                    count_d = count_q + NB_COUNT'(1);
                    shift_d = assembled;
                end
            end

            // A read in the completing cycle frees the slot for the new word.
            if (word_done) begin
                if (!valid_q || bus.i_word_read) begin
                    word_d  = assembled;
                    valid_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end else if (bus.i_word_read) begin
                valid_d = 1'b0;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            count_q   <= '0;
            shift_q   <= '0;
            word_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            shift_q   <= shift_d;
            word_q    <= word_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.o_word       = word_q;
    assign bus.o_word_valid = valid_q;
    assign bus.o_byte_count = count_q;
    assign bus.o_overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_word_assembler.sv
// Bench: two assemblers (LSB-first with a 10-cycle timeout, MSB-first with no timeout)
// share one stimulus stream and are checked against a byte-list reference model.
module tb_uart_rx_word_assembler;

    logic i_clock = 1'b0;
    logic i_reset = 1'b1;

    always #5 i_clock = ~i_clock;

    uart_rx_word_assembler_if #(.NB_DATA(32), .NB_BYTE(8)) bus_a ();
    uart_rx_word_assembler_if #(.NB_DATA(32), .NB_BYTE(8)) bus_b ();

    uart_rx_word_assembler #(.NB_DATA(32), .NB_BYTE(8), .LSB_FIRST(1'b1),
                             .NB_TIMEOUT(16), .TIMEOUT_CYCLES(10)) dut_a (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .bus     (bus_a)
    );

    uart_rx_word_assembler #(.NB_DATA(32), .NB_BYTE(8), .LSB_FIRST(1'b0),
                             .NB_TIMEOUT(16), .TIMEOUT_CYCLES(0)) dut_b (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .bus     (bus_b)
    );

    int total = 0;
    int bad   = 0;

    // current inputs (shared by both DUTs)
    logic [7:0] cur_b;
    logic       cur_done, cur_read, cur_flush;

    // reference model: list of bytes received so far, silence length, holding register
    int          tmo[2] = '{10, 0};
    bit          lsb[2] = '{1'b1, 1'b0};
    int          m_n[2];
    int          m_sil[2];
    logic [7:0]  m_b[2][4];
    logic [31:0] m_word[2];
    bit          m_valid[2];
    bit          m_ovr[2];

    task automatic chk(input string name, input int d, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s dut%0d got=%h exp=%h t=%0t", name, d, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_n[d] = 0; m_sil[d] = 0; m_word[d] = 32'h0; m_valid[d] = 0; m_ovr[d] = 0;
        end
    endtask

    // Compare one DUT against the model for the current cycle, then advance the model.
    task automatic model_cycle(input int d);
        logic [31:0] g_word, w;
        logic        g_valid, g_tp, g_op, g_ovr;
        logic [2:0]  g_cnt;
        bit          fire, comp, expire;
        if (d == 0) begin
            g_word = bus_a.o_word; g_valid = bus_a.o_word_valid; g_cnt = bus_a.o_byte_count;
            g_tp = bus_a.o_timeout_pulse; g_op = bus_a.o_overrun_pulse; g_ovr = bus_a.o_overrun;
        end else begin
            g_word = bus_b.o_word; g_valid = bus_b.o_word_valid; g_cnt = bus_b.o_byte_count;
            g_tp = bus_b.o_timeout_pulse; g_op = bus_b.o_overrun_pulse; g_ovr = bus_b.o_overrun;
        end
        fire   = cur_done && !cur_flush;
        comp   = fire && (m_n[d] == 3);
        expire = !cur_flush && !cur_done && (m_n[d] > 0) && (tmo[d] != 0) && (m_sil[d] + 1 == tmo[d]);

        chk("m_word",  d, g_word,  m_word[d]);
        chk("m_valid", d, 32'(g_valid), 32'(m_valid[d]));
        chk("m_count", d, 32'(g_cnt),   32'(m_n[d]));
        chk("m_tpulse",d, 32'(g_tp),    32'(expire));
        chk("m_opulse",d, 32'(g_op),    32'(comp && m_valid[d] && !cur_read));
        chk("m_ovr",   d, 32'(g_ovr),   32'(m_ovr[d]));

        if (cur_flush) begin
            m_n[d] = 0; m_sil[d] = 0; m_valid[d] = 0; m_ovr[d] = 0;
        end else begin
            if (fire) begin
                m_b[d][m_n[d]] = cur_b;
                m_sil[d] = 0;
                if (comp) begin
                    w = 32'h0;
                    for (int k = 0; k < 4; k++)
                        w = w | (32'(m_b[d][k]) << (lsb[d] ? 8 * k : 8 * (3 - k)));
                    m_n[d] = 0;
                    if (!m_valid[d] || cur_read) begin
                        m_word[d] = w; m_valid[d] = 1;
                    end else begin
                        m_ovr[d] = 1;
                    end
                end else begin
                    m_n[d]++;
                end
            end else if (m_n[d] > 0) begin
                if (expire) begin m_n[d] = 0; m_sil[d] = 0; end
                else m_sil[d]++;
            end
            if (!comp && cur_read) m_valid[d] = 0;
        end
    endtask

    task automatic set_in(input logic [7:0] b, input logic done, input logic rd, input logic fl);
        cur_b = b; cur_done = done; cur_read = rd; cur_flush = fl;
        bus_a.i_rx_byte = b; bus_a.i_rx_done_pulse = done; bus_a.i_word_read = rd; bus_a.i_flush = fl;
        bus_b.i_rx_byte = b; bus_b.i_rx_done_pulse = done; bus_b.i_word_read = rd; bus_b.i_flush = fl;
    endtask

    // Apply inputs for one cycle and check at the falling edge; adv() moves past the next rising edge.
    task automatic drive(input logic [7:0] b, input logic done, input logic rd, input logic fl);
        set_in(b, done, rd, fl);
        @(negedge i_clock);
        model_cycle(0);
        model_cycle(1);
    endtask

    task automatic adv();
        @(posedge i_clock);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        drive(b, 1'b1, 1'b0, 1'b0);
        adv();
    endtask

    typedef struct {
        logic [7:0]  b;
        logic        done, read, flush;
        int          rep;
        logic [31:0] word;
        logic        valid;
        logic [2:0]  cnt;
        logic        tp, op, ovr;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{8'h78, 1, 0, 0, 1, 32'h0,        0, 3'd0, 0, 0, 0};
        vecs[1]  = '{8'h00, 0, 0, 0, 3, 32'h0,        0, 3'd1, 0, 0, 0};
        vecs[2]  = '{8'h56, 1, 0, 0, 1, 32'h0,        0, 3'd1, 0, 0, 0};
        vecs[3]  = '{8'h00, 0, 0, 0, 3, 32'h0,        0, 3'd2, 0, 0, 0};
        vecs[4]  = '{8'h34, 1, 0, 0, 1, 32'h0,        0, 3'd2, 0, 0, 0};
        vecs[5]  = '{8'h00, 0, 0, 0, 3, 32'h0,        0, 3'd3, 0, 0, 0};
        vecs[6]  = '{8'h12, 1, 0, 0, 1, 32'h0,        0, 3'd3, 0, 0, 0};
        vecs[7]  = '{8'h00, 0, 0, 0, 1, 32'h12345678, 1, 3'd0, 0, 0, 0};
        vecs[8]  = '{8'h00, 0, 1, 0, 1, 32'h12345678, 1, 3'd0, 0, 0, 0};
        vecs[9]  = '{8'h00, 0, 0, 0, 1, 32'h12345678, 0, 3'd0, 0, 0, 0};
        vecs[10] = '{8'h00, 0, 1, 0, 1, 32'h12345678, 0, 3'd0, 0, 0, 0};
        vecs[11] = '{8'h00, 0, 0, 0, 2, 32'h12345678, 0, 3'd0, 0, 0, 0};

        set_in(8'h00, 1'b0, 1'b0, 1'b0);
        model_reset();
        #12;
        chk("rst_word",  0, bus_a.o_word, 32'h0);
        chk("rst_count", 0, 32'(bus_a.o_byte_count), 32'd0);
        chk("rst_valid", 1, 32'(bus_b.o_word_valid), 32'd0);
        @(posedge i_clock);
        #1 i_reset = 1'b0;

        // table: LSB-first word with spaced pulses, then read behaviour
        for (int i = 0; i < 12; i++) begin
            for (int r = 0; r < vecs[i].rep; r++) begin
                drive(vecs[i].b, vecs[i].done, vecs[i].read, vecs[i].flush);
                chk("tbl_word",   0, bus_a.o_word, vecs[i].word);
                chk("tbl_valid",  0, 32'(bus_a.o_word_valid), 32'(vecs[i].valid));
                chk("tbl_count",  0, 32'(bus_a.o_byte_count), 32'(vecs[i].cnt));
                chk("tbl_tpulse", 0, 32'(bus_a.o_timeout_pulse), 32'(vecs[i].tp));
                chk("tbl_opulse", 0, 32'(bus_a.o_overrun_pulse), 32'(vecs[i].op));
                chk("tbl_ovr",    0, 32'(bus_a.o_overrun), 32'(vecs[i].ovr));
                adv();
            end
        end
        chk("msb_word", 1, bus_b.o_word, 32'h78563412);

        // timeout after two bytes, then a clean word
        send(8'hAA);
        send(8'hBB);
        for (int i = 1; i <= 12; i++) begin
            drive(8'h00, 1'b0, 1'b0, 1'b0);
            chk("to_pulse", 0, 32'(bus_a.o_timeout_pulse), 32'(i == 10));
            chk("to_count", 0, 32'(bus_a.o_byte_count), (i <= 10) ? 32'd2 : 32'd0);
            adv();
        end
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        chk("to_word",  0, bus_a.o_word, 32'h04030201);
        chk("to_valid", 0, 32'(bus_a.o_word_valid), 32'd1);
        adv();

        // flush to realign both DUTs
        drive(8'h00, 1'b0, 1'b0, 1'b1);
        adv();

        // overrun: A unread, then B completes
        for (int k = 0; k < 4; k++) send(8'h11);
        for (int k = 0; k < 3; k++) send(8'h22);
        drive(8'h22, 1'b1, 1'b0, 1'b0);
        chk("ovr_pulse", 0, 32'(bus_a.o_overrun_pulse), 32'd1);
        adv();
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        chk("ovr_flag", 0, 32'(bus_a.o_overrun), 32'd1);
        chk("ovr_word", 0, bus_a.o_word, 32'h11111111);
        adv();

        // read coincident with the completing byte: no overrun, new word loaded
        for (int k = 0; k < 3; k++) send(8'h22);
        drive(8'h22, 1'b1, 1'b1, 1'b0);
        chk("rdc_pulse", 0, 32'(bus_a.o_overrun_pulse), 32'd0);
        adv();
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        chk("rdc_word",  0, bus_a.o_word, 32'h22222222);
        chk("rdc_valid", 0, 32'(bus_a.o_word_valid), 32'd1);
        adv();

        // flush with a coincident byte after two bytes
        send(8'h55); send(8'h66);
        drive(8'h77, 1'b1, 1'b0, 1'b1);
        adv();
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        chk("fl_count", 0, 32'(bus_a.o_byte_count), 32'd0);
        chk("fl_valid", 0, 32'(bus_a.o_word_valid), 32'd0);
        chk("fl_ovr",   0, 32'(bus_a.o_overrun), 32'd0);
        chk("fl_word",  0, bus_a.o_word, 32'h22222222);
        adv();
        send(8'h88);
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        chk("fl_count1", 0, 32'(bus_a.o_byte_count), 32'd1);
        adv();
        send(8'h99); send(8'hAA); send(8'hBB);
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        chk("fl_word2", 0, bus_a.o_word, 32'hBBAA9988);
        adv();

        // asynchronous reset mid-word
        send(8'h01); send(8'h02); send(8'h03);
        set_in(8'h00, 1'b0, 1'b0, 1'b0);
        #2 i_reset = 1'b1;
        #1;
        chk("ar_count_a", 0, 32'(bus_a.o_byte_count), 32'd0);
        chk("ar_count_b", 1, 32'(bus_b.o_byte_count), 32'd0);
        chk("ar_valid",   0, 32'(bus_a.o_word_valid), 32'd0);
        chk("ar_word",    0, bus_a.o_word, 32'h0);
        model_reset();
        #3 i_reset = 1'b0;
        adv();
        send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        chk("ar_word_a", 0, bus_a.o_word, 32'hEFBEADDE);
        chk("ar_word_b", 1, bus_b.o_word, 32'hDEADBEEF);
        adv();

        // randomized traffic against the model
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 99) < 4) begin
                for (int g = 0; g < int'($urandom_range(8, 14)); g++) begin
                    drive(8'h00, 1'b0, 1'($urandom_range(0, 3) == 0), 1'b0);
                    adv();
                end
            end else begin
                drive(8'($urandom_range(0, 255)), 1'($urandom_range(0, 99) < 40),
                      1'($urandom_range(0, 99) < 20), 1'($urandom_range(0, 99) < 2));
                adv();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
